// File: rtl/prbs_checker.sv
// Receive-side checker for the 4-bit Fibonacci LFSR pattern generator.
// Self-synchronises to the incoming sequence, then flags, counts and tracks loss of lock.
module prbs_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [1:0]           state_dbg
);

  // Handshake: a word is consumed on every rising edge where in_valid is high;
  // there is no backpressure, so the checker accepts one word per valid cycle.

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] LOSS_LAST = BW'(LOSS_COUNT - 1);

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1] ^ x[WIDTH-2]};
  endfunction

  state_t               state, state_nx;
  logic [WIDTH-1:0]     exp_word, exp_nx;
  logic [GW-1:0]        good_cnt, good_nx;
  logic [BW-1:0]        bad_cnt, bad_nx;
  logic                 err_hit;
  logic                 locked_nx, err_pulse_nx;
  logic [ERR_CNT_W-1:0] err_count_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= SEARCH;
      exp_word  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      exp_word  <= exp_nx;
      good_cnt  <= good_nx;
      bad_cnt   <= bad_nx;
      locked    <= locked_nx;
      err_pulse <= err_pulse_nx;
      err_count <= err_count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    exp_nx   = exp_word;
    good_nx  = good_cnt;
    bad_nx   = bad_cnt;
    err_hit  = 1'b0;
    if (in_valid) begin
      case (state)
        SEARCH: begin
          // All-zero is the LFSR lock-up value and can never seed a prediction.
          if (in_data != '0) begin
            exp_nx   = lfsr_next(in_data);
            good_nx  = '0;
            state_nx = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == exp_word) begin
            exp_nx  = lfsr_next(in_data);
            good_nx = good_cnt + 1'b1;
            if (good_cnt == LOCK_LAST) begin
              state_nx = LOCKED;
              bad_nx   = '0;
            end
          end else if (in_data != '0) begin
            exp_nx  = lfsr_next(in_data);
            good_nx = '0;
          end else begin
            state_nx = SEARCH;
          end
        end
        LOCKED: begin
          // Free-run from the prediction so one corrupted word costs one error.
          exp_nx = lfsr_next(exp_word);
          if (in_data == exp_word) begin
            bad_nx = '0;
          end else begin
            err_hit = 1'b1;
            bad_nx  = bad_cnt + 1'b1;
            if (bad_cnt == LOSS_LAST) begin
              state_nx = SEARCH;
              good_nx  = '0;
            end
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked_nx    = (state_nx == LOCKED);
    err_pulse_nx = err_hit;
    err_count_nx = err_count;
    if (clear_err) begin
      err_count_nx = ERR_CNT_W'(err_hit);
    end else if (err_hit && (err_count != '1)) begin
      err_count_nx = err_count + 1'b1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: default instance plus a 2-bit error-counter instance,
// both checked every cycle against a sequence-table reference model.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       reset, in_valid, clear_err;
  logic [3:0] in_data;
  logic       locked_a, pulse_a, locked_b, pulse_b;
  logic [15:0] cnt_a;
  logic [1:0] cnt_b, dbg_a, dbg_b;

  always #5 clk = ~clk;

  prbs_checker dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(locked_a), .err_pulse(pulse_a),
    .err_count(cnt_a), .state_dbg(dbg_a)
  );

  prbs_checker #(.ERR_CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_err(clear_err), .locked(locked_b), .err_pulse(pulse_b),
    .err_count(cnt_b), .state_dbg(dbg_b)
  );

  localparam int LOCK_N = 4;
  localparam int LOSS_N = 3;

  logic [3:0] seq [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                           4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};

  logic [21:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: position within the 15-entry sequence table.
  int m_mode = 0;   // 0 search, 1 verify, 2 locked
  int m_pos = 0;
  int m_run = 0;
  int m_bad = 0;
  int m_cnt_a = 0;
  int m_cnt_b = 0;
  bit m_pulse = 0;
  int sp = 0;

  function automatic int idx_of(input logic [3:0] w);
    for (int i = 0; i < 15; i++) if (seq[i] == w) return i;
    return 0;
  endfunction

  task automatic model_step(input bit v, input logic [3:0] d, input bit clr, input bit rst);
    bit err;
    logic [3:0] pred;
    err = 0;
    if (rst) begin
      m_mode = 0; m_pos = 0; m_run = 0; m_bad = 0;
      m_cnt_a = 0; m_cnt_b = 0; m_pulse = 0;
      return;
    end
    pred = seq[(m_pos + 1) % 15];
    if (v) begin
      if (m_mode == 0) begin
        if (d != 4'h0) begin m_pos = idx_of(d); m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (d == pred) begin
          m_pos = (m_pos + 1) % 15;
          m_run++;
          if (m_run == LOCK_N) begin m_mode = 2; m_bad = 0; end
        end else if (d != 4'h0) begin
          m_pos = idx_of(d); m_run = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        m_pos = (m_pos + 1) % 15;
        if (d == pred) m_bad = 0;
        else begin
          err = 1;
          m_bad++;
          if (m_bad == LOSS_N) begin m_mode = 0; m_run = 0; end
        end
      end
    end
    m_pulse = err;
    if (clr) begin
      m_cnt_a = int'(err);
      m_cnt_b = int'(err);
    end else if (err) begin
      if (m_cnt_a < 65535) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
  endtask

  task automatic step(input bit v, input logic [3:0] d, input bit clr, input bit rst);
    bit lk;
    in_valid = v; in_data = d; clear_err = clr; reset = rst;
    @(posedge clk);
    model_step(v, d, clr, rst);
    lk = (m_mode == 2);
    exp_q.push_back({lk, m_pulse, 16'(m_cnt_a), lk, m_pulse, 2'(m_cnt_b)});
    #1;
  endtask

  task automatic good();
    step(1, seq[sp], 0, 0); sp = (sp + 1) % 15;
  endtask
  task automatic bad();
    step(1, seq[sp] ^ 4'h6, 0, 0); sp = (sp + 1) % 15;
  endtask
  task automatic idle();
    step(0, 4'($urandom_range(0, 15)), 0, 0);
  endtask
  task automatic do_reset();
    step(0, 4'h0, 0, 1); sp = 0;
  endtask

  always @(negedge clk) begin
    logic [21:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {locked_a, pulse_a, cnt_a, locked_b, pulse_b, cnt_b};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL out_check t=%0t act=%h exp=%h (locked,pulse,cnt16,locked,pulse,cnt2)",
                 $time, a, e);
      end
    end
  end

  initial begin
    reset = 1; in_valid = 0; in_data = 0; clear_err = 0;
    do_reset(); do_reset();
    // Acquire
    repeat (5) good();
    // Single error: 2 replaced by 3, then 4,9,3
    step(1, 4'h3, 0, 0); sp = (sp + 1) % 15;
    repeat (3) good();
    // Loss: run on to expected 4,9,3 and send zeros instead, then re-lock
    while (sp != 6) good();
    repeat (3) begin step(1, 4'h0, 0, 0); sp = (sp + 1) % 15; end
    repeat (5) good();
    // Zeros in SEARCH, then acquisition with idle garbage between words
    do_reset();
    step(1, 4'h0, 0, 0); step(1, 4'h0, 0, 0);
    repeat (5) begin good(); idle(); end
    // Isolated errors to saturate the narrow counter, then clears
    repeat (5) begin bad(); good(); end
    step(1, seq[sp] ^ 4'h6, 1, 0); sp = (sp + 1) % 15;
    good();
    step(0, 4'h0, 1, 0);
    good();
    // Reset mid-operation and re-lock
    bad(); good(); bad(); good();
    do_reset();
    repeat (5) good();
    // Randomised stream with corruption, idles, clears and occasional resets
    repeat (2000) begin
      int r;
      bit c;
      r = $urandom_range(0, 199);
      c = ($urandom_range(0, 29) == 0);
      if (r < 2) begin
        do_reset(); sp = $urandom_range(0, 14);
      end else if (r < 40) begin
        step(0, 4'($urandom_range(0, 15)), c, 0);
      end else if (r < 52) begin
        step(1, 4'($urandom_range(0, 15)), c, 0); sp = (sp + 1) % 15;
      end else begin
        step(1, seq[sp], c, 0); sp = (sp + 1) % 15;
      end
    end
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain act=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
